k5290_line_seq: RTL and testbench
=================================

Name: k5290_line_seq

Overview:
- Sequencer that drives the K005290 tileline latch.
- Per layer (tilemap A and tilemap B) it generates:
  - the 8-pixel character phase (2HD, 4HD_n)
  - the latch strobes
  - the 74194 mode selects (9E pins)
  - the per-tile flip selects (AFF/BFF)
- It applies a per-layer fine horizontal scroll, so the load boundary moves within the 8-pixel slot.
- Sits between the video timing generator / attribute fetch and the K005290 datapath.

Parameters:
- HCNT_W, 9, width of the horizontal pixel counter output.
- HB_HOLD, 1, 1 = shift registers hold (mode 00) during HBLANK; 0 = keep shifting.

Ports:
- i_MCLK  in  1  main clock, 48 MHz. The block's only clock.
- i_RST_n  in  1  reset. Synchronous, active-low.
- i_CEN_px  in  1  6 MHz pixel clock enable, one i_MCLK cycle wide.
- i_LINE_START  in  1  restarts the phase and pixel counters. Qualified by i_CEN_px.
- i_HBLANK  in  1  horizontal blank.
- i_A_FLIP  in  1  tile A flip attribute. Sampled on the A latch cycle.
- i_B_FLIP  in  1  tile B flip attribute. Sampled on the B latch cycle.
- i_A_FINE  in  3  tilemap A fine scroll, 0..7. Sampled at line start.
- i_B_FINE  in  3  tilemap B fine scroll, 0..7. Sampled at line start.
- o_2HD  out  1  phase bit 1 to K005290.
- o_4HD_n  out  1  inverted phase bit 2 to K005290.
- o_A_LATCH  out  1  one-i_MCLK pulse: tile A char data valid, latch now.
- o_B_LATCH  out  1  one-i_MCLK pulse: tile B char data valid, latch now.
- o_A_MODE  out  2  {9E_pin11, 9E_pin3} for the A shift registers.
- o_B_MODE  out  2  {9E_pin8, 9E_pin6} for the B shift registers.
- o_AFF  out  1  tile A flip select, aligned to pixel output.
- o_BFF  out  1  tile B flip select, aligned to pixel output.
- o_HCNT  out  HCNT_W  horizontal pixel count.

Behaviour:
- Reset values (i_RST_n low at an i_MCLK edge):
  - phase counter ph = 0, o_HCNT = 0
  - o_2HD = 0, o_4HD_n = 1
  - latch pulses = 0
  - modes = 2'b00
  - o_AFF = o_BFF = 0, pending flips = 0
  - latched fine values = 0
- Reset overrides every other input. Reset mid-line leaves the block idle until the next i_LINE_START or i_CEN_px.
- Counters, updated only on i_CEN_px cycles:
  - ph (3 bit) increments and wraps 7 -> 0.
  - o_HCNT increments and wraps at 2^HCNT_W -> 0.
  - If i_LINE_START is also high: ph = 0, o_HCNT = 0, and fine_A / fine_B <= i_A_FINE / i_B_FINE. Line start wins over increment.
- Strobes: o_2HD = ph[1], o_4HD_n = ~ph[2]. Registered, unscrolled.
- Per-layer slots, computed from the current ph (3-bit modular arithmetic):
  - load slot: ph == (7 + fine) mod 8
  - A latch slot: ph == (load slot - 4) mod 8
  - B latch slot: ph == (load slot - 2) mod 8
- Latch pulse: high for exactly the one i_MCLK cycle where i_CEN_px and ph == latch slot. On that cycle the layer's flip input is captured into flip_pend.
- Mode output (registered, applied from the i_CEN_px cycle onward):
  - On the load slot: 2'b11 (parallel load), and o_xFF <= flip_pend.
  - Else, if HB_HOLD and i_HBLANK: 2'b00 (hold).
  - Else, shift: 2'b01 when o_xFF == 0, 2'b10 when o_xFF == 1.
- Flip always changes exactly at the tile boundary, never mid-tile.
- Fine-value change mid-line is ignored until the next line start.
- i_HBLANK asserted on a load slot: load still occurs. Load has priority over hold.
- Between i_CEN_px cycles all outputs are stable, except that latch pulses return to 0.

Decomposition:
- Package k5290_seq_pkg:
  - MODE_HOLD = 2'b00, MODE_SHR = 2'b01, MODE_SHL = 2'b10, MODE_LOAD = 2'b11
  - latch offsets A_LAT_OFS = 4, B_LAT_OFS = 2
- Sub-module k5290_layer_slot, instantiated twice (A and B). Parameters: latch offset. Owns the fine register, slot compare, flip_pend, o_xFF and mode generation.
- The top level owns ph, o_HCNT and the strobes.

Test Plan:
1. Reset low 3 cycles, then high with i_CEN_px idle -> o_4HD_n = 1, o_2HD = 0, modes = 00, o_HCNT = 0, all pulses 0.
2. fine = 0, free-run 16 pixels after line start -> per 8 pixels:
   - o_A_LATCH at ph = 3, o_B_LATCH at ph = 5
   - mode 11 at ph = 7, otherwise 01
   - o_2HD/o_4HD_n follow ph 0..7
3. i_A_FINE = 5 at line start -> A load at ph = 4, A latch at ph = 0; B (fine 0) unchanged. Change i_A_FINE mid-line -> no effect until the next line start.
4. i_A_FLIP = 1 at tile n latch, 0 at tile n+1 -> o_AFF rises at tile n load, falls at tile n+1 load; mode 10 during tile n, 01 after.
5. i_HBLANK = 1 spanning a load slot -> mode 00 on non-load pixels, 11 on the load slot; i_LINE_START with i_CEN_px at ph = 6 -> ph = 0 next, no increment.
6. Assert i_RST_n low at ph = 4 with a latch pulse pending -> next cycle all outputs at reset values, no pulse emitted.

Source files
------------

// File: rtl/k5290_line_seq_pkg.sv
// rtl/k5290_line_seq_pkg.sv - shared mode encodings and latch offsets for the K005290 line sequencer
package k5290_seq_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Character data for each layer is latched this many pixels ahead of its load slot.
    localparam int A_LAT_OFS = 4;
    localparam int B_LAT_OFS = 2;

endpackage

// File: rtl/k5290_line_seq_if.sv
// rtl/k5290_line_seq_if.sv - per-layer link between the phase counter and one slot generator
interface k5290_line_seq_if;
    logic       cen;
    logic       line_start;
    logic       hblank;
    logic       flip;
    logic [2:0] ph;
    logic [2:0] fine;
    logic       latch;
    logic       ff;
    logic [1:0] mode;

    modport master (
        output cen, line_start, hblank, flip, ph, fine,
        input  latch, ff, mode
    );

    modport slave (
        input  cen, line_start, hblank, flip, ph, fine,
        output latch, ff, mode
    );
endinterface

// File: rtl/k5290_line_seq_layer_slot.sv
// rtl/k5290_line_seq_layer_slot.sv - scrolled load/latch slots, flip pipeline and 74194 mode for one layer
module k5290_layer_slot
    import k5290_seq_pkg::*;
#(
    parameter int LAT_OFS = 4,
    parameter bit HB_HOLD = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    k5290_line_seq_if.slave   s
);

    logic [2:0] r_fine;
    logic       r_flip_pend;
    logic       r_ff;
    logic       r_latch;
    logic [1:0] r_mode;

    logic [2:0] w_load_slot;
    logic [2:0] w_latch_slot;

    // Fine scroll slides the tile boundary; all slot arithmetic is mod 8.
    assign w_load_slot  = r_fine + 3'd7;
    assign w_latch_slot = w_load_slot - 3'(LAT_OFS);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fine      <= 3'd0;
            r_flip_pend <= 1'b0;
            r_ff        <= 1'b0;
            r_latch     <= 1'b0;
            r_mode      <= MODE_HOLD;
        end else begin
            r_latch <= 1'b0;
            if (s.cen) begin
                if (s.ph == w_latch_slot) begin
                    r_latch     <= 1'b1;
                    r_flip_pend <= s.flip;
                end
                // Flip is only transferred on load so it never changes mid-tile.
                if (s.ph == w_load_slot) begin
                    r_mode <= MODE_LOAD;
                    r_ff   <= r_flip_pend;
                end else if (HB_HOLD && s.hblank) begin
                    r_mode <= MODE_HOLD;
                end else begin
                    r_mode <= r_ff ? MODE_SHL : MODE_SHR;
                end
                if (s.line_start) begin
                    r_fine <= s.fine;
                end
            end
        end
    end

    assign s.latch = r_latch;
    assign s.ff    = r_ff;
    assign s.mode  = r_mode;

endmodule

// File: rtl/k5290_line_seq.sv
// rtl/k5290_line_seq.sv - K005290 tileline latch sequencer: phase/pixel counters, strobes, two layer slots
module k5290_line_seq
    import k5290_seq_pkg::*;
#(
    parameter int HCNT_W  = 9,
    parameter bit HB_HOLD = 1'b1
) (
    input  logic              i_MCLK,
    input  logic              i_RST_n,
    input  logic              i_CEN_px,
    input  logic              i_LINE_START,
    input  logic              i_HBLANK,
    input  logic              i_A_FLIP,
    input  logic              i_B_FLIP,
    input  logic [2:0]        i_A_FINE,
    input  logic [2:0]        i_B_FINE,
    output logic              o_2HD,
    output logic              o_4HD_n,
    output logic              o_A_LATCH,
    output logic              o_B_LATCH,
    output logic [1:0]        o_A_MODE,
    output logic [1:0]        o_B_MODE,
    output logic              o_AFF,
    output logic              o_BFF,
    output logic [HCNT_W-1:0] o_HCNT
);

    logic [2:0]        r_ph;
    logic [HCNT_W-1:0] r_hcnt;
    logic              r_2hd;
    logic              r_4hd_n;

    logic [2:0]        w_ph_nxt;
    logic [HCNT_W-1:0] w_hcnt_nxt;

    assign w_ph_nxt   = i_LINE_START ? 3'd0 : r_ph + 3'd1;
    assign w_hcnt_nxt = i_LINE_START ? '0 : r_hcnt + HCNT_W'(1);

    // Strobes are derived from the next phase so they always track r_ph.
    always_ff @(posedge i_MCLK) begin
        if (!i_RST_n) begin
            r_ph    <= 3'd0;
            r_hcnt  <= '0;
            r_2hd   <= 1'b0;
            r_4hd_n <= 1'b1;
        end else if (i_CEN_px) begin
            r_ph    <= w_ph_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_2hd   <= w_ph_nxt[1];
            r_4hd_n <= ~w_ph_nxt[2];
        end
    end

    k5290_line_seq_if u_if_a ();
    k5290_line_seq_if u_if_b ();

    assign u_if_a.cen        = i_CEN_px;
    assign u_if_a.line_start = i_LINE_START;
    assign u_if_a.hblank     = i_HBLANK;
    assign u_if_a.flip       = i_A_FLIP;
    assign u_if_a.ph         = r_ph;
    assign u_if_a.fine       = i_A_FINE;

    assign u_if_b.cen        = i_CEN_px;
    assign u_if_b.line_start = i_LINE_START;
    assign u_if_b.hblank     = i_HBLANK;
    assign u_if_b.flip       = i_B_FLIP;
    assign u_if_b.ph         = r_ph;
    assign u_if_b.fine       = i_B_FINE;

    k5290_layer_slot #(.LAT_OFS(A_LAT_OFS), .HB_HOLD(HB_HOLD)) u_slot_a (
        .i_clk   (i_MCLK),
        .i_rst_n (i_RST_n),
        .s       (u_if_a.slave)
    );

    k5290_layer_slot #(.LAT_OFS(B_LAT_OFS), .HB_HOLD(HB_HOLD)) u_slot_b (
        .i_clk   (i_MCLK),
        .i_rst_n (i_RST_n),
        .s       (u_if_b.slave)
    );

    assign o_2HD     = r_2hd;
    assign o_4HD_n   = r_4hd_n;
    assign o_HCNT    = r_hcnt;
    assign o_A_LATCH = u_if_a.latch;
    assign o_B_LATCH = u_if_b.latch;
    assign o_A_MODE  = u_if_a.mode;
    assign o_B_MODE  = u_if_b.mode;
    assign o_AFF     = u_if_a.ff;
    assign o_BFF     = u_if_b.ff;

endmodule

// File: tb/tb_k5290_line_seq.sv
// tb/tb_k5290_line_seq.sv - table-driven and scoreboard bench for k5290_line_seq
module tb_k5290_line_seq;

    logic       clk;
    logic       rst_n;
    logic       hblank;
    logic       b_flip;
    logic [2:0] b_fine;
    logic       w_2hd, w_4hd_n, w_b_latch, w_bff;
    logic [1:0] w_b_mode;
    logic [8:0] w_hcnt;

    k5290_line_seq_if tb_if ();
    assign tb_if.ph = w_hcnt[2:0];

    k5290_line_seq dut (
        .i_MCLK       (clk),
        .i_RST_n      (rst_n),
        .i_CEN_px     (tb_if.cen),
        .i_LINE_START (tb_if.line_start),
        .i_HBLANK     (hblank),
        .i_A_FLIP     (tb_if.flip),
        .i_B_FLIP     (b_flip),
        .i_A_FINE     (tb_if.fine),
        .i_B_FINE     (b_fine),
        .o_2HD        (w_2hd),
        .o_4HD_n      (w_4hd_n),
        .o_A_LATCH    (tb_if.latch),
        .o_B_LATCH    (w_b_latch),
        .o_A_MODE     (tb_if.mode),
        .o_B_MODE     (w_b_mode),
        .o_AFF        (tb_if.ff),
        .o_BFF        (w_bff),
        .o_HCNT       (w_hcnt)
    );

    assign tb_if.hblank = hblank;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct packed {
        logic [2:0] ph;
        logic [8:0] hcnt;
        logic       d2, d4n, la, lb;
        logic [1:0] ma, mb;
        logic       aff, bff;
    } exp_t;

    typedef struct {
        logic       la, lb;
        logic [1:0] ma, mb;
        logic       d2, d4n;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[8];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [2:0] m_ph, m_fa, m_fb;
    logic [8:0] m_hcnt;
    logic       m_pa, m_pb, m_aff, m_bff, m_la, m_lb;
    logic [1:0] m_ma, m_mb;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] shift_mode(input logic ff);
        return ff ? 2'b10 : 2'b01;
    endfunction

    // One MCLK cycle: advance the reference model, queue its expectation, clock, then compare.
    task automatic step(input logic rst, input logic cen, input logic ls);
        exp_t e;
        logic lda, ldb;
        rst_n = rst;
        tb_if.cen = cen;
        tb_if.line_start = ls;
        if (!rst) begin
            m_ph = 0; m_hcnt = 0; m_fa = 0; m_fb = 0; m_pa = 0; m_pb = 0;
            m_aff = 0; m_bff = 0; m_la = 0; m_lb = 0; m_ma = 0; m_mb = 0;
        end else begin
            m_la = 0;
            m_lb = 0;
            if (cen) begin
                lda = (m_ph == 3'(m_fa + 3'd7));
                ldb = (m_ph == 3'(m_fb + 3'd7));
                if (m_ph == 3'(m_fa + 3'd3)) begin m_la = 1; m_pa = tb_if.flip; end
                if (m_ph == 3'(m_fb + 3'd5)) begin m_lb = 1; m_pb = b_flip; end
                if (lda) begin m_ma = 2'b11; m_aff = m_pa; end
                else if (hblank) m_ma = 2'b00;
                else m_ma = shift_mode(m_aff);
                if (ldb) begin m_mb = 2'b11; m_bff = m_pb; end
                else if (hblank) m_mb = 2'b00;
                else m_mb = shift_mode(m_bff);
                if (ls) begin
                    m_ph = 0; m_hcnt = 0; m_fa = tb_if.fine; m_fb = b_fine;
                end else begin
                    m_ph = m_ph + 3'd1; m_hcnt = m_hcnt + 9'd1;
                end
            end
        end
        e = '{ph: m_ph, hcnt: m_hcnt, d2: m_ph[1], d4n: ~m_ph[2], la: m_la, lb: m_lb,
              ma: m_ma, mb: m_mb, aff: m_aff, bff: m_bff};
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("sb_ph",   16'(tb_if.ph),    16'(e.ph));
        chk("sb_hcnt", 16'(w_hcnt),      16'(e.hcnt));
        chk("sb_2hd",  16'(w_2hd),       16'(e.d2));
        chk("sb_4hdn", 16'(w_4hd_n),     16'(e.d4n));
        chk("sb_alat", 16'(tb_if.latch), 16'(e.la));
        chk("sb_blat", 16'(w_b_latch),   16'(e.lb));
        chk("sb_amode",16'(tb_if.mode),  16'(e.ma));
        chk("sb_bmode",16'(w_b_mode),    16'(e.mb));
        chk("sb_aff",  16'(tb_if.ff),    16'(e.aff));
        chk("sb_bff",  16'(w_bff),       16'(e.bff));
    endtask

    task automatic pixel(input logic ls);
        step(1'b1, 1'b1, ls);
        step(1'b1, 1'b0, 1'b0);
    endtask

    // Checks taken after the cen edge of a pixel, before the idle cycle.
    task automatic line_start_px();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Expected outputs after the cen edge taken at phase = index, fine 0, no flip.
        tbl[0] = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 2'b11, 2'b11, 1'b0, 1'b1};

        hblank = 0; b_flip = 0; b_fine = 0;
        tb_if.flip = 0; tb_if.fine = 0; tb_if.cen = 0; tb_if.line_start = 0; rst_n = 0;

        // Reset, then idle.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        chk("rst_4hdn", 16'(w_4hd_n), 16'd1);
        chk("rst_hcnt", 16'(w_hcnt), 16'd0);

        // Free-run two tiles with fine 0 against the table.
        line_start_px();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("tbl_alat", 16'(tb_if.latch), 16'(tbl[i % 8].la));
            chk("tbl_blat", 16'(w_b_latch),   16'(tbl[i % 8].lb));
            chk("tbl_amode",16'(tb_if.mode),  16'(tbl[i % 8].ma));
            chk("tbl_bmode",16'(w_b_mode),    16'(tbl[i % 8].mb));
            chk("tbl_2hd",  16'(w_2hd),       16'(tbl[i % 8].d2));
            chk("tbl_4hdn", 16'(w_4hd_n),     16'(tbl[i % 8].d4n));
            step(1'b1, 1'b0, 1'b0);
        end

        // A fine scroll 5: load at ph 4, latch at ph 0; mid-line change ignored.
        tb_if.fine = 3'd5;
        line_start_px();
        for (int i = 0; i < 16; i++) begin
            if (i == 3) tb_if.fine = 3'd2;
            step(1'b1, 1'b1, 1'b0);
            if (i % 8 == 0) chk("fine_alat", 16'(tb_if.latch), 16'd1);
            if (i % 8 == 4) chk("fine_aload", 16'(tb_if.mode), 16'd3);
            if (i % 8 == 7) chk("fine_bload", 16'(w_b_mode), 16'd3);
            step(1'b1, 1'b0, 1'b0);
        end
        tb_if.fine = 3'd0;

        // Flip on tile n only.
        line_start_px();
        for (int i = 0; i < 24; i++) begin
            tb_if.flip = (i == 3);
            b_flip = (i == 13);
            step(1'b1, 1'b1, 1'b0);
            if (i == 7)  chk("flip_aff_rise", 16'(tb_if.ff), 16'd1);
            if (i == 10) chk("flip_amode_shl", 16'(tb_if.mode), 16'd2);
            if (i == 15) chk("flip_aff_fall", 16'(tb_if.ff), 16'd0);
            if (i == 17) chk("flip_amode_shr", 16'(tb_if.mode), 16'd1);
            if (i == 15) chk("flip_bff_rise", 16'(w_bff), 16'd1);
            step(1'b1, 1'b0, 1'b0);
        end
        tb_if.flip = 0; b_flip = 0;

        // HBLANK spanning a load slot, then line start at ph 6.
        line_start_px();
        for (int i = 0; i < 14; i++) begin
            hblank = (i >= 5 && i <= 9);
            step(1'b1, 1'b1, (i == 13) ? 1'b0 : 1'b0);
            if (i == 6) chk("hb_hold", 16'(tb_if.mode), 16'd0);
            if (i == 7) chk("hb_load", 16'(tb_if.mode), 16'd3);
            if (i == 8) chk("hb_hold2", 16'(w_b_mode), 16'd0);
            step(1'b1, 1'b0, 1'b0);
        end
        hblank = 0;
        chk("ls_ph6_pre", 16'(tb_if.ph), 16'd6);
        step(1'b1, 1'b1, 1'b1);
        chk("ls_ph6_ph", 16'(tb_if.ph), 16'd0);
        chk("ls_ph6_hcnt", 16'(w_hcnt), 16'd0);
        step(1'b1, 1'b0, 1'b0);

        // Reset while an A latch pulse is high at ph 4.
        line_start_px();
        for (int i = 0; i < 3; i++) pixel(1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("pre_rst_alat", 16'(tb_if.latch), 16'd1);
        step(1'b0, 1'b1, 1'b0);
        chk("rst_alat", 16'(tb_if.latch), 16'd0);
        chk("rst_mode", 16'(tb_if.mode), 16'd0);
        chk("rst_4hdn2", 16'(w_4hd_n), 16'd1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
